flip_t_frame_ctrl: RTL and testbench
====================================

Name: flip_t_frame_ctrl

Overview:
- Frame sequencer for the flip_t datapath inside the energy-detection FIL build.
- Accepts a fixed-length frame of samples on a valid/ready input stream and drives flip_t's clock enable and data input.
- Tracks the datapath latency with a token delay line and presents results on a valid/ready output stream with frame-last marking.
- Stalls the datapath by deasserting its enable under output backpressure, and reports per-frame completion status.

Parameters:
- DATA_W, 8, sample width; must match flip_t data_in/data_out.
- FRAME_LEN, 256, samples per frame; legal range 2..65535.
- LATENCY, 2, enabled-clock cycles from flip_t data_in to data_out; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- abort  in  1  one-cycle pulse; cancels the current frame.
- s_data  in  DATA_W  input sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller accepts s_data this cycle.
- m_data  out  DATA_W  result sample, driven directly from dut_dout.
- m_valid  out  1  result valid.
- m_last  out  1  result is the final sample of the frame.
- m_ready  in  1  downstream accepts the result.
- dut_enb  out  1  flip_t clock enable.
- dut_din  out  DATA_W  flip_t data input.
- dut_dout  in  DATA_W  flip_t data output.
- dut_rst  out  1  active-high datapath reset.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at frame completion.
- frame_cnt  out  16  completed-frame count.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE; vld_pipe and last_pipe cleared; frame_cnt=0; in_cnt=0; all outputs 0 except dut_rst=1.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE->RUN on start.
  - RUN->DRAIN on acceptance of the sample where in_cnt==FRAME_LEN-1.
  - DRAIN->DONE when vld_pipe==0.
  - DONE->IDLE unconditionally.
  - start outside IDLE is ignored.
- Handshake and stepping:
  - can_adv = !m_valid | m_ready.
  - s_ready = (state==RUN) & can_adv & !abort.
  - accept = s_valid & s_ready.
  - step = can_adv & !abort & (accept | (|vld_pipe)).
  - dut_enb = step.
  - dut_din = accept ? s_data : 0. Non-accept steps insert bubbles.
- Token pipes: LATENCY-bit shift registers that advance only on step.
  - vld_pipe input = accept.
  - last_pipe input = accept & (in_cnt==FRAME_LEN-1).
  - m_valid = vld_pipe[LATENCY-1].
  - m_last = last_pipe[LATENCY-1] & m_valid.
- Ordering guarantees:
  - m_valid & !m_ready forces step=0, so dut_dout and m_valid hold stable.
  - A consumed output always advances the pipe, so no result is duplicated or lost.
  - Results leave in input order.
- in_cnt: increments on accept; cleared on entry to RUN and on abort.
- frame_cnt: increments in DONE; wraps 0xFFFF->0.
- done is 1 only in DONE. busy = (state!=IDLE).
- Abort:
  - Has priority over start, accept and step in the same cycle.
  - Next cycle: state=IDLE, pipes cleared, in_cnt=0, m_valid=0.
  - frame_cnt unchanged; done not pulsed.
- dut_rst = reset | abort, combinational, so flip_t registers are flushed in the abort cycle.
- Empty-input stall: in RUN with vld_pipe==0 and s_valid=0, the datapath holds (dut_enb=0).

Decomposition:
- Package flip_t_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the DATA_W default;
  - the FRAME_CNT_W=16 constant.
- One sub-module, flip_t_tok_pipe: parameterised LATENCY-deep shift register of {valid, last} with enable and synchronous clear. It is instantiated once.

Test Plan (FRAME_LEN=4, LATENCY=2, flip_t model = 2-cycle enabled delay with bit reversal):
- Reset: assert reset for 3 cycles -> all outputs 0, dut_rst=1, frame_cnt=0; release -> dut_rst=0, busy=0.
- Full-rate frame, accept cycles t0..t3:
  - Stimulus: start, then s_valid=1 with 0x01,0x02,0x03,0x04; m_ready=1.
  - s_ready=1 in t0..t3.
  - m_valid t2..t5 with data 0x80,0x40,0xC0,0x20; m_last only at t5.
  - done=1 at t7; frame_cnt=1 at t8; busy=0 at t8.
- Backpressure: hold m_ready=0 for 5 cycles while m_valid=1 -> dut_enb=0, s_ready=0, m_data stable; release -> remaining 3 results in order, no duplicates.
- Input gaps: s_valid pattern 1,0,0,1,1,0,1 -> bubble steps drain pending results; exactly 4 outputs in order; m_last on the 4th.
- Abort mid-frame: abort after 2 accepts -> dut_rst=1 and dut_enb=0 that cycle; next cycle IDLE, m_valid=0, frame_cnt unchanged, no done; a following start plus 4 samples completes normally.
- Command collisions:
  - start while in RUN -> ignored, in_cnt unaffected.
  - start and abort in the same IDLE cycle -> remains IDLE.
  - frame_cnt preset by 65535 frames -> wraps to 0.

Source files
------------

// File: rtl/flip_t_ctrl_pkg.sv
// Shared types and constants for the flip_t frame sequencer.
package flip_t_ctrl_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/flip_t_tok_pipe.sv
// LATENCY-deep {valid, last} token shift register that mirrors the flip_t
// datapath occupancy; it advances only when the datapath is clock-enabled.
module flip_t_tok_pipe #(
    parameter int LATENCY = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               vld_i,
    input  logic               last_i,
    output logic [LATENCY-1:0] vld_o,
    output logic               last_o
);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] last_q, last_d;

    // Next token state: flush on clear, shift one slot per enabled cycle.
    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        if (clr_i) begin
            vld_d  = {LATENCY{1'b0}};
            last_d = {LATENCY{1'b0}};
        end else if (en_i) begin
            vld_d[0]  = vld_i;
            last_d[0] = last_i;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i]  = vld_q[i-1];
                last_d[i] = last_q[i-1];
            end
        end else begin
            vld_d  = vld_q;
            last_d = last_q;
        end
    end

    // Token registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_q  <= {LATENCY{1'b0}};
            last_q <= {LATENCY{1'b0}};
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign vld_o  = vld_q;
    assign last_o = last_q[LATENCY-1];

endmodule

// File: rtl/flip_t_frame_ctrl.sv
// Frame sequencer for flip_t: feeds one fixed-length frame through the datapath,
// stalls it under output backpressure and reports frame completion.
module flip_t_frame_ctrl
    import flip_t_ctrl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = 256,
    parameter int LATENCY   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   dut_enb,
    output logic [DATA_W-1:0]      dut_din,
    input  logic [DATA_W-1:0]      dut_dout,
    output logic                   dut_rst,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_e                 state_q, state_d;
    logic [15:0]            in_cnt_q, in_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [LATENCY-1:0]     vld_pipe_s;
    logic                   last_tail_s;
    logic                   can_adv_s;
    logic                   accept_s;
    logic                   step_s;
    logic                   is_last_s;

    flip_t_tok_pipe #(
        .LATENCY (LATENCY)
    ) u_tok_pipe (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (abort),
        .en_i    (step_s),
        .vld_i   (accept_s),
        .last_i  (accept_s & is_last_s),
        .vld_o   (vld_pipe_s),
        .last_o  (last_tail_s)
    );

    // Handshake and datapath stepping; abort masks every forward action.
    always_comb begin
        m_valid   = vld_pipe_s[LATENCY-1];
        m_last    = last_tail_s & m_valid;
        m_data    = dut_dout;
        can_adv_s = ~m_valid | m_ready;
        is_last_s = (in_cnt_q == LAST_IDX);
        s_ready   = (state_q == RUN) & can_adv_s & ~abort;
        accept_s  = s_valid & s_ready;
        step_s    = can_adv_s & ~abort & (accept_s | (|vld_pipe_s));
        dut_enb   = step_s;
        dut_din   = accept_s ? s_data : {DATA_W{1'b0}};
        dut_rst   = reset | abort;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        frame_cnt = frame_cnt_q;
    end

    // Frame state machine and counters.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (abort) begin
            state_d  = IDLE;
            in_cnt_d = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = RUN;
                        in_cnt_d = 16'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        in_cnt_d = in_cnt_q + 16'd1;
                        state_d  = is_last_s ? DRAIN : RUN;
                    end else begin
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (vld_pipe_s == {LATENCY{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                DONE: begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_cnt_q    <= 16'd0;
            frame_cnt_q <= {FRAME_CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_flip_t_frame_ctrl.sv
// Bench for flip_t_frame_ctrl: flip_t modelled as a 2-cycle enabled delay with
// bit reversal; a token-queue model predicts the stream behaviour.
module tb_flip_t_frame_ctrl;

    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 4;
    localparam int LATENCY   = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic              dut_enb;
    logic [DATA_W-1:0] dut_din;
    logic [DATA_W-1:0] dut_dout;
    logic              dut_rst;
    logic              busy;
    logic              done;
    logic [15:0]       frame_cnt;

    flip_t_frame_ctrl #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .dut_enb   (dut_enb),
        .dut_din   (dut_din),
        .dut_dout  (dut_dout),
        .dut_rst   (dut_rst),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // flip_t stand-in: two enabled register stages, bit-reversed.
    logic [7:0] fr0, fr1;
    always @(posedge clk) begin
        if (dut_rst) begin
            fr0 <= 8'h00;
            fr1 <= 8'h00;
        end else if (dut_enb) begin
            fr0 <= bitrev(dut_din);
            fr1 <= fr0;
        end
    end
    assign dut_dout = fr1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: accepted-but-unconsumed tokens with their step count.
    typedef struct {
        logic [7:0] d;
        logic       last;
        int         steps;
    } tok_t;

    tok_t        q[$];
    logic        mdl_active   = 1'b0;
    int          mdl_cnt      = 0;
    logic [15:0] mdl_frames   = 16'd0;
    int          cyc          = 0;
    int          last_pop_cyc = -10;
    int          out_cnt      = 0;

    logic       smp_sr, smp_mv, smp_ml, smp_en, smp_dn, smp_by, smp_rs, smp_acc;
    logic [7:0] smp_md;
    logic [15:0] smp_fc;

    // One clock: sample away from the edge, check against the model, advance.
    task automatic tick();
        logic legal, exp_mv, can, exp_sr, acc, exp_en, exp_dn;
        tok_t t;
        #2;
        smp_sr = s_ready; smp_mv = m_valid; smp_ml = m_last; smp_en = dut_enb;
        smp_dn = done;    smp_by = busy;    smp_rs = dut_rst; smp_md = m_data;
        smp_fc = frame_cnt;

        exp_mv = (q.size() > 0) && (q[0].steps == LATENCY - 1);
        chk_eq("m_valid", smp_mv, exp_mv);
        if (exp_mv) begin
            chk_eq("m_data", smp_md, q[0].d);
            chk_eq("m_last", smp_ml, q[0].last);
        end else begin
            chk_eq("m_last_idle", smp_ml, 1'b0);
        end
        legal  = mdl_active && (mdl_cnt < FRAME_LEN) && !abort;
        can    = !exp_mv || m_ready;
        exp_sr = legal && can;
        chk_eq("s_ready", smp_sr, exp_sr);
        acc     = s_valid && exp_sr;
        smp_acc = s_valid && smp_sr;
        exp_en  = can && !abort && (acc || q.size() > 0);
        chk_eq("dut_enb", smp_en, exp_en);
        if (exp_en) chk_eq("dut_din", dut_din, acc ? s_data : 8'h00);
        chk_eq("dut_rst", smp_rs, abort);
        exp_dn = mdl_active && (mdl_cnt == FRAME_LEN) && (cyc == last_pop_cyc + 2);
        chk_eq("done", smp_dn, exp_dn);
        chk_eq("busy", smp_by, mdl_active);
        chk_eq("frame_cnt", smp_fc, mdl_frames);

        if (abort) begin
            q.delete();
            mdl_active = 1'b0;
            mdl_cnt    = 0;
        end else begin
            if (exp_en) begin
                if (exp_mv) begin
                    if (q[0].last) last_pop_cyc = cyc;
                    void'(q.pop_front());
                    out_cnt++;
                end
                for (int i = 0; i < q.size(); i++) begin
                    t = q[i];
                    t.steps++;
                    q[i] = t;
                end
                if (acc) begin
                    t.d = bitrev(s_data); t.last = (mdl_cnt == FRAME_LEN - 1); t.steps = 0;
                    q.push_back(t);
                    mdl_cnt++;
                end
            end
            if (exp_dn) begin
                mdl_frames = mdl_frames + 16'd1;
                mdl_active = 1'b0;
            end else if (start && !mdl_active) begin
                mdl_active = 1'b1;
                mdl_cnt    = 0;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic finish_frame(input int start_idx, input logic [7:0] base);
        int   idx  = start_idx;
        logic seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            start = 1'b0; abort = 1'b0; m_ready = 1'b1;
            s_valid = (idx < FRAME_LEN);
            s_data  = base + 8'(idx);
            tick();
            if (smp_acc) idx++;
            if (smp_dn) seen = 1'b1;
        end
        chk_eq("frame_done", seen, 1'b1);
        s_valid = 1'b0;
        tick();
    endtask

    task automatic run_frame(input logic [7:0] base);
        start = 1'b1; s_valid = 1'b0; abort = 1'b0;
        tick();
        start = 1'b0;
        finish_frame(0, base);
    endtask

    localparam logic [7:0] FR_DATA [4] = '{8'h80, 8'h40, 8'hC0, 8'h20};
    localparam logic       GAP_PAT [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int          idx;
        int          oc0;
        logic [15:0] fc0;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b0;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_eq("rst_s_ready", s_ready, 1'b0);
            chk_eq("rst_m_valid", m_valid, 1'b0);
            chk_eq("rst_m_last", m_last, 1'b0);
            chk_eq("rst_dut_enb", dut_enb, 1'b0);
            chk_eq("rst_dut_din", dut_din, 8'h00);
            chk_eq("rst_dut_rst", dut_rst, 1'b1);
            chk_eq("rst_busy", busy, 1'b0);
            chk_eq("rst_done", done, 1'b0);
            chk_eq("rst_frame_cnt", frame_cnt, 16'h0000);
            chk_eq("rst_m_data", m_data, 8'h00);
        end
        reset = 1'b0;
        tick();
        chk_eq("rel_dut_rst", smp_rs, 1'b0);
        chk_eq("rel_busy", smp_by, 1'b0);

        // full-rate frame, cycle-exact
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 0; t < 9; t++) begin
            s_valid = (t < 4); s_data = 8'(t + 1); m_ready = 1'b1;
            tick();
            chk_eq("fr_s_ready", smp_sr, (t < 4));
            chk_eq("fr_m_valid", smp_mv, (t >= 2 && t <= 5));
            if (t >= 2 && t <= 5) chk_eq("fr_m_data", smp_md, FR_DATA[t-2]);
            chk_eq("fr_m_last", smp_ml, (t == 5));
            chk_eq("fr_done", smp_dn, (t == 7));
            if (t == 8) begin
                chk_eq("fr_busy_end", smp_by, 1'b0);
                chk_eq("fr_frame_cnt", smp_fc, 16'd1);
            end
        end
        s_valid = 1'b0;

        // backpressure: five stalled cycles with a result waiting
        oc0 = out_cnt;
        start = 1'b1; tick(); start = 1'b0;
        idx = 0; m_ready = 1'b0;
        for (int t = 0; t < 2; t++) begin
            s_valid = 1'b1; s_data = 8'h10 + 8'(idx);
            tick();
            if (smp_acc) idx++;
        end
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_data = 8'h10 + 8'(idx);
            tick();
            chk_eq("bp_m_valid", smp_mv, 1'b1);
            chk_eq("bp_dut_enb", smp_en, 1'b0);
            chk_eq("bp_s_ready", smp_sr, 1'b0);
            chk_eq("bp_m_data", smp_md, 8'h08);
        end
        finish_frame(idx, 8'h10);
        chk_eq("bp_out_count", out_cnt - oc0, 4);

        // input gaps
        oc0 = out_cnt; idx = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int p = 0; p < 7; p++) begin
            s_valid = GAP_PAT[p]; s_data = 8'hA0 + 8'(idx); m_ready = 1'b1;
            tick();
            if (smp_acc) idx++;
        end
        chk_eq("gap_accepts", idx, 4);
        finish_frame(idx, 8'hA0);
        chk_eq("gap_out_count", out_cnt - oc0, 4);

        // abort after two accepts
        fc0 = mdl_frames; idx = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 10 && idx < 2; c++) begin
            s_valid = 1'b1; s_data = 8'h30 + 8'(idx); m_ready = 1'b1;
            tick();
            if (smp_acc) idx++;
        end
        abort = 1'b1; s_valid = 1'b1;
        tick();
        chk_eq("ab_dut_rst", smp_rs, 1'b1);
        chk_eq("ab_dut_enb", smp_en, 1'b0);
        chk_eq("ab_s_ready", smp_sr, 1'b0);
        abort = 1'b0; s_valid = 1'b0;
        tick();
        chk_eq("ab_busy", smp_by, 1'b0);
        chk_eq("ab_m_valid", smp_mv, 1'b0);
        chk_eq("ab_done", smp_dn, 1'b0);
        chk_eq("ab_frame_cnt", smp_fc, fc0);
        run_frame(8'h50);
        chk_eq("ab_recover_cnt", frame_cnt, fc0 + 16'd1);

        // start while running is ignored
        oc0 = out_cnt; idx = 0; fc0 = mdl_frames;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 10 && idx < 2; c++) begin
            s_valid = 1'b1; s_data = 8'h60 + 8'(idx); m_ready = 1'b1;
            tick();
            if (smp_acc) idx++;
        end
        start = 1'b1; s_valid = 1'b1; s_data = 8'h60 + 8'(idx);
        tick();
        if (smp_acc) idx++;
        finish_frame(idx, 8'h60);
        chk_eq("col_out_count", out_cnt - oc0, 4);
        chk_eq("col_frame_cnt", frame_cnt, fc0 + 16'd1);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0; tick();
        chk_eq("sa_busy", smp_by, 1'b0);

        // completed-frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        mdl_frames = 16'hFFFF;
        run_frame(8'h70);
        chk_eq("wrap_frame_cnt", frame_cnt, 16'h0000);

        // randomized traffic against the model
        for (int c = 0; c < 2500; c++) begin
            start   = ($urandom_range(0, 7) == 0);
            abort   = ($urandom_range(0, 99) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        start = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
